// File: rtl/input_framer.sv
// ---------------------------------------------------------------------------
// input_framer
//
// Packs FRAME_LEN consecutive 4-bit samples from an unthrottled upstream
// stream into one frame, tracks the label of the first sample and flags any
// later sample whose label differs, then hands the frame to a downstream
// valid/ready output register. Upstream cannot be stalled, so words that
// arrive while a finished frame is still waiting for the output register
// are dropped and recorded in a sticky overflow flag.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-low reset
//   in_valid     upstream strobe; Xin is consumed on every edge it is 1
//   Xin          [6:3] sample, [2:0] label
//   frame_ready  downstream accepts the frame when frame_valid is also 1
//   frame_data   packed frame, sample k at [4k+3:4k], k=0 first received
//   frame_label  label of the frame's first sample
//   frame_err    some sample in the frame had a label other than frame_label
//   frame_valid  output register holds a frame
//   overflow     sticky: at least one input word dropped since reset
//   frame_count  frames accepted downstream since reset (wraps)
// ---------------------------------------------------------------------------
module input_framer #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [6:0]             Xin,
  input  logic                   frame_ready,
  output logic [4*FRAME_LEN-1:0] frame_data,
  output logic [2:0]             frame_label,
  output logic                   frame_err,
  output logic                   frame_valid,
  output logic                   overflow,
  output logic [CNT_W-1:0]       frame_count
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          fill_cnt_q, fill_cnt_d;
  logic [4*FRAME_LEN-1:0] asm_data_q, asm_data_d;
  logic [2:0]             asm_label_q, asm_label_d;
  logic                   asm_err_q, asm_err_d;
  logic                   complete_q, complete_d;
  logic [4*FRAME_LEN-1:0] out_data_q, out_data_d;
  logic [2:0]             out_label_q, out_label_d;
  logic                   out_err_q, out_err_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   transfer;
  logic                   accept;

  // Next-state logic for the assembly FSM, the assembly register and the
  // output holding register. complete_q marks a finished frame still sitting
  // in the assembly register; HOLD is only ever entered with it set.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    asm_data_d  = asm_data_q;
    asm_label_d = asm_label_q;
    asm_err_d   = asm_err_q;
    complete_d  = complete_q;
    out_data_d  = out_data_q;
    out_label_d = out_label_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    count_d     = count_q;

    accept   = out_valid_q && frame_ready;
    transfer = complete_q && (!out_valid_q || frame_ready);

    case (state_q)
      FILL: begin
        if (complete_q && !transfer) begin
          // The finished frame cannot move yet and the assembly register
          // is occupied, so this edge's word has nowhere to go.
          state_d = HOLD;
          if (in_valid) overflow_d = 1'b1;
        end else begin
          if (transfer) complete_d = 1'b0;
          if (in_valid) begin
            // The frame being transferred is read from the _q copy, so the
            // next frame's slot 0 can be written on the same edge.
            for (int k = 0; k < FRAME_LEN; k++) begin
              if (fill_cnt_q == k[CW-1:0]) asm_data_d[4*k +: 4] = Xin[6:3];
            end
            if (fill_cnt_q == '0) begin
              asm_label_d = Xin[2:0];
              asm_err_d   = 1'b0;
            end else if (Xin[2:0] != asm_label_q) begin
              asm_err_d = 1'b1;
            end
            if (fill_cnt_q == LAST_SLOT) begin
              fill_cnt_d = '0;
              complete_d = 1'b1;
            end else begin
              fill_cnt_d = fill_cnt_q + CW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (in_valid) overflow_d = 1'b1;
        if (transfer) begin
          state_d    = FILL;
          complete_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase

    if (transfer) begin
      out_data_d  = asm_data_q;
      out_label_d = asm_label_q;
      out_err_d   = asm_err_q;
      out_valid_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    if (accept) count_d = count_q + CNT_W'(1);
  end

  // State registers with synchronous active-low reset; a partial frame and
  // any word presented during reset are simply discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      asm_data_q  <= '0;
      asm_label_q <= '0;
      asm_err_q   <= 1'b0;
      complete_q  <= 1'b0;
      out_data_q  <= '0;
      out_label_q <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      asm_data_q  <= asm_data_d;
      asm_label_q <= asm_label_d;
      asm_err_q   <= asm_err_d;
      complete_q  <= complete_d;
      out_data_q  <= out_data_d;
      out_label_q <= out_label_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  assign frame_data  = out_data_q;
  assign frame_label = out_label_q;
  assign frame_err   = out_err_q;
  assign frame_valid = out_valid_q;
  assign overflow    = overflow_q;
  assign frame_count = count_q;

endmodule
